// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: PC owner and fetch/exec sequencer for the 5-bit CPU.
// Each instruction takes 3 clocks (FETCH, WAIT, EXEC). The CU's jump decision is sampled in EXEC.
module instr_fetch_seq #(
    parameter int              ADDR_W     = 5,
    parameter int              OPND_W     = 5,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [3:0]      HALT_OP    = 4'b0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stall,
    output logic                imem_rd_en,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [3+OPND_W:0]   imem_data,
    output logic [3:0]          opcode,
    output logic [OPND_W-1:0]   operand,
    output logic                instr_valid,
    input  logic                jmp_sel,
    output logic [ADDR_W-1:0]   pc,
    output logic                halted
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, EXEC, HALT} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [3+OPND_W:0]   ir_q, ir_d;
    logic                halted_q, halted_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        halted_d = halted_q;
        case (state_q)
            IDLE: if (start) begin
                pc_d    = START_ADDR;
                state_d = FETCH;
            end
            FETCH: state_d = stall ? FETCH : WAIT;
            WAIT: begin
                ir_d    = imem_data;
                state_d = EXEC;
            end
            EXEC: if (opcode == HALT_OP) begin
                halted_d = 1'b1;
                state_d  = HALT;
            end else begin
                // jump targets narrower than the operand simply drop the upper bits
                pc_d    = jmp_sel ? operand[ADDR_W-1:0] : pc_q + 1'b1;
                state_d = FETCH;
            end
            HALT: if (start) begin
                halted_d = 1'b0;
                pc_d     = START_ADDR;
                state_d  = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_rd_en  = (state_q == FETCH) && !stall;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign opcode      = ir_q[3+OPND_W:OPND_W];
    assign operand     = ir_q[OPND_W-1:0];
    assign instr_valid = (state_q == EXEC);
    assign halted      = halted_q;
endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb_instr_fetch_seq: directed bench for instr_fetch_seq with a synchronous instruction memory model.
// A second instance with START_ADDR=31 covers start-at-top and PC wrap.
module tb_instr_fetch_seq;
    logic       clk = 1'b0;
    logic       rst_n, start, stall, jmp_sel, start31;
    logic       rd_en, valid, halted;
    logic [4:0] addr, operand, pc;
    logic [3:0] opcode;
    logic [8:0] data;
    logic       b_rd_en, b_valid, b_halted;
    logic [4:0] b_addr, b_operand, b_pc;
    logic [3:0] b_opcode;
    logic [8:0] b_data;
    logic [8:0] mem [32];
    int         n_chk = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    instr_fetch_seq u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .imem_rd_en(rd_en), .imem_addr(addr), .imem_data(data),
        .opcode(opcode), .operand(operand), .instr_valid(valid),
        .jmp_sel(jmp_sel), .pc(pc), .halted(halted)
    );

    instr_fetch_seq #(.START_ADDR(5'd31)) u_dut31 (
        .clk(clk), .rst_n(rst_n), .start(start31), .stall(1'b0),
        .imem_rd_en(b_rd_en), .imem_addr(b_addr), .imem_data(b_data),
        .opcode(b_opcode), .operand(b_operand), .instr_valid(b_valid),
        .jmp_sel(1'b0), .pc(b_pc), .halted(b_halted)
    );

    always @(posedge clk) begin
        if (rd_en) data <= mem[addr];
        if (b_rd_en) b_data <= mem[b_addr];
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Entered at a negedge in FETCH with stall low; leaves at the negedge after EXEC.
    task automatic run_instr(input logic jmp, input int a, input int op, input int opnd);
        chk("fetch_rd_en", rd_en, 1);
        chk("fetch_addr", addr, a);
        step();
        chk("wait_rd_en", rd_en, 0);
        chk("wait_valid", valid, 0);
        step();
        chk("exec_valid", valid, 1);
        chk("exec_opcode", opcode, op);
        chk("exec_operand", operand, opnd);
        jmp_sel = jmp;
        step();
        jmp_sel = 1'b0;
        chk("post_exec_valid", valid, 0);
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 32; i++) mem[i] = {4'h1, 5'(i)};
        mem[2]  = {4'h2, 5'd2};
        mem[4]  = {4'h3, 5'd12};
        mem[5]  = {4'h3, 5'd30};
        mem[12] = {4'h3, 5'd4};
        mem[31] = {4'h1, 5'd4};
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; jmp_sel = 1'b0; start31 = 1'b0;
        step(); step();
        chk("rst_pc", pc, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_operand", operand, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_valid", valid, 0);
        chk("rst_halted", halted, 0);
        rst_n = 1'b1;
        step();
        chk("idle_rd_en", rd_en, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        run_instr(0, 0, 1, 0);
        chk("pc_inc1", pc, 1);
        run_instr(0, 1, 1, 1);
        run_instr(0, 2, 2, 2);
        chk("hold_opcode", opcode, 2);
        chk("hold_operand", operand, 2);
        chk("pc_inc3", pc, 3);
        mem[2] = {4'h0, 5'd7};
        run_instr(0, 3, 1, 3);
        run_instr(1, 4, 3, 12);
        run_instr(1, 12, 3, 4);
        run_instr(0, 4, 3, 12);
        stall = 1'b1;
        #1;
        chk("stall_rd_en_now", rd_en, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_rd_en", rd_en, 0);
            chk("stall_pc", pc, 5);
            chk("stall_ir", opcode, 3);
        end
        stall = 1'b0;
        #1;
        chk("stall_operand", operand, 12);
        run_instr(1, 5, 3, 30);
        run_instr(0, 30, 1, 30);
        run_instr(0, 31, 1, 4);
        chk("wrap_pc", pc, 0);
        chk("wrap_halted", halted, 0);
        run_instr(0, 0, 1, 0);
        run_instr(0, 1, 1, 1);
        jmp_sel = 1'b1;
        run_instr(1, 2, 0, 7);
        chk("halt_halted", halted, 1);
        chk("halt_pc", pc, 2);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cnt += int'(rd_en);
            cnt += int'(valid);
        end
        chk("halt_quiet", cnt, 0);
        chk("halt_held", halted, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_halted", halted, 0);
        run_instr(0, 0, 1, 0);
        chk("fetch_rd_en", rd_en, 1);
        chk("fetch_addr", addr, 1);
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_pc", pc, 0);
        chk("arst_opcode", opcode, 0);
        chk("arst_operand", operand, 0);
        chk("arst_rd_en", rd_en, 0);
        chk("arst_valid", valid, 0);
        chk("arst_halted", halted, 0);
        step();
        rst_n = 1'b1;
        step(); step();
        chk("post_rst_idle", rd_en, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        run_instr(0, 0, 1, 0);
        start31 = 1'b1;
        step();
        start31 = 1'b0;
        chk("s31_rd_en", b_rd_en, 1);
        chk("s31_addr", b_addr, 31);
        step(); step();
        chk("s31_valid", b_valid, 1);
        chk("s31_opcode", b_opcode, 1);
        chk("s31_operand", b_operand, 4);
        step();
        chk("s31_wrap_addr", b_addr, 0);
        chk("s31_wrap_rd_en", b_rd_en, 1);
        chk("s31_halted", b_halted, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
